round_key_sequencer: RTL and testbench
======================================

Name: round_key_sequencer

Overview:
Stage directly downstream of key expansion. It captures the full expanded key schedule (nr+1 round keys, 128 bits each) when the schedule valid strobe is high. On each start request it streams the round keys one per handshake to the iterative round datapath. Order is ascending for encryption and descending for decryption.

Parameters:
nk, 4, key length in 32-bit words (4/6/8); informational, must match upstream key expansion
nr, 10, number of rounds (10/12/14); schedule holds nr+1 round keys

Ports:
i_clk  input  1  clock, all logic on rising edge
i_rst  input  1  synchronous active-high reset
i_w  input  128*(nr+1)  expanded schedule, MSB-first [0:...]; round key k occupies bits [128*k +: 128]
i_vld  input  1  schedule valid (level) from key expansion
i_start  input  1  request to stream one block's round keys
i_dec  input  1  direction, sampled with accepted i_start; 0 = rounds 0..nr, 1 = rounds nr..0
i_rdy  input  1  downstream accepts o_key this cycle
o_key  output  128  current round key, MSB-first [0:127]
o_round  output  4  index of round key on o_key
o_vld  output  1  o_key/o_round valid
o_last  output  1  current key is the final one of the stream
o_key_loaded  output  1  a schedule has been captured since reset
o_err  output  1  one-cycle pulse: start requested with no schedule loaded

Behaviour:
- Reset (i_rst=1 at a clock edge): state IDLE; r_sched cleared; o_key=0, o_round=0, o_vld=0, o_last=0, o_key_loaded=0, o_err=0. Reset mid-stream aborts the stream and no further keys are presented.
- States: IDLE, STREAM.
- Schedule capture: in IDLE with i_vld=1, r_sched <= i_w and o_key_loaded <= 1. A level-high i_vld reloads every cycle. i_vld in STREAM is ignored, so the schedule is stable for the whole stream.
- IDLE -> STREAM: i_start=1 and (o_key_loaded=1 or i_vld=1).
  - If i_vld and i_start are both high in the same cycle, the stream uses the newly presented i_w.
  - Next cycle: o_vld=1, o_round=0 (enc) or nr (dec), and o_key = the corresponding slice.
  - Latency from i_start to first valid key is 1 cycle.
- i_start with o_key_loaded=0 and i_vld=0: remain in IDLE; o_err=1 for exactly the next cycle.
- STREAM handshake:
  - A transfer occurs when o_vld=1 and i_rdy=1.
  - On a transfer, o_round steps +1 (enc) or -1 (dec) and o_key updates on the next cycle.
  - With o_vld=1 and i_rdy=0, o_key, o_round and o_last hold stable.
  - o_vld never drops mid-stream.
- o_last = 1 while o_round==nr (enc) or o_round==0 (dec).
- Transfer with o_last=1: next cycle state IDLE, o_vld=0, o_last=0; o_key/o_round hold their last values.
- i_start during STREAM is ignored, including the last-transfer cycle. The minimum gap between streams is 1 idle cycle, giving a stream period of nr+2 cycles with i_rdy tied high.
- o_round width is 4 bits, covering nr<=14. The index never wraps: enc stops at nr and dec stops at 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset then load: FIPS-197 AES-128 key 000102..0f expanded schedule on i_w with i_vld=1 for one cycle -> o_key_loaded=1, o_vld=0.
- Encrypt stream, i_rdy=1: pulse i_start with i_dec=0.
  - Required sequence: o_round 0..10 on consecutive cycles.
  - Round 0: o_key=000102030405060708090a0b0c0d0e0f.
  - Round 1: o_key=d6aa74fdd2af72fadaa678f1d6ab76fe.
  - Round 10: o_key=13111d7fe3944a17f307a78b4d2b30c5, o_last=1 on round 10 only.
  - o_vld=0 on the following cycle.
- Decrypt stream with backpressure: i_start with i_dec=1, i_rdy toggled 1,0,0,1,...
  - First key must be round 10 (13111d7f...), held stable during i_rdy=0 cycles.
  - Rounds must follow 10..0 and end with 000102..0f, o_last=1.
- Start without key: after reset, i_start=1 with i_vld=0 -> o_err=1 for one cycle, o_vld stays 0.
- Reload ignored while busy: during STREAM drive i_vld=1 with a different schedule -> the remaining keys come from the original schedule. Once back in IDLE, the new schedule is captured.
- Reset mid-stream: assert i_rst at round 4 -> next cycle o_vld=0, o_key=0, o_key_loaded=0.

Source files
------------

// File: rtl/round_key_sequencer.sv
// Holds the expanded AES key schedule and streams one round key per handshake, ascending
// for encryption and descending for decryption; first key 1 cycle after start, holds on !i_rdy.
module round_key_sequencer #(
    parameter int nk = 4,
    parameter int nr = 10
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [0:128*(nr+1)-1]  i_w,
    input  logic                   i_vld,
    input  logic                   i_start,
    input  logic                   i_dec,
    input  logic                   i_rdy,
    output logic [0:127]           o_key,
    output logic [3:0]             o_round,
    output logic                   o_vld,
    output logic                   o_last,
    output logic                   o_key_loaded,
    output logic                   o_err
);

    localparam int          SCHED_W    = 128 * (nr + 1);
    localparam logic [3:0]  LAST_ROUND = 4'(nr);

    // Key length and round count come from the same upstream configuration.
    if (nk + 6 != nr) begin : g_bad_cfg
        $error("round_key_sequencer: nr must equal nk + 6");
    end

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t              state;
    logic [0:SCHED_W-1]  r_sched;
    logic                r_dec;

    logic [3:0]          nxt_round;
    logic                nxt_last;
    logic [0:SCHED_W-1]  start_sched;
    logic [3:0]          start_round;

    function automatic logic [0:127] key_of(input logic [0:SCHED_W-1] s, input logic [3:0] idx);
        key_of = s[128*int'(idx) +: 128];
    endfunction

    always_comb begin
        nxt_round   = r_dec ? (o_round - 4'd1) : (o_round + 4'd1);
        nxt_last    = r_dec ? (nxt_round == 4'd0) : (nxt_round == LAST_ROUND);
        // A schedule arriving with the start request is the one streamed.
        start_sched = i_vld ? i_w : r_sched;
        start_round = i_dec ? LAST_ROUND : 4'd0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            r_sched      <= '0;
            r_dec        <= 1'b0;
            o_key        <= '0;
            o_round      <= 4'd0;
            o_vld        <= 1'b0;
            o_last       <= 1'b0;
            o_key_loaded <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_vld) begin
                        r_sched      <= i_w;
                        o_key_loaded <= 1'b1;
                    end
                    if (i_start) begin
                        if (o_key_loaded || i_vld) begin
                            state   <= STREAM;
                            r_dec   <= i_dec;
                            o_vld   <= 1'b1;
                            o_round <= start_round;
                            o_key   <= key_of(start_sched, start_round);
                            o_last  <= (LAST_ROUND == 4'd0);
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (i_rdy) begin
                        if (o_last) begin
                            // Key and index stay on the bus after the final transfer.
                            state  <= IDLE;
                            o_vld  <= 1'b0;
                            o_last <= 1'b0;
                        end else begin
                            o_round <= nxt_round;
                            o_key   <= key_of(r_sched, nxt_round);
                            o_last  <= nxt_last;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_round_key_sequencer.sv
// Directed bench for round_key_sequencer using the FIPS-197 AES-128 key 000102..0f schedule.
module tb_round_key_sequencer;

    localparam int NR = 10;
    localparam int SW = 128 * (NR + 1);

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic [0:SW-1]   i_w;
    logic            i_vld;
    logic            i_start;
    logic            i_dec;
    logic            i_rdy;
    logic [0:127]    o_key;
    logic [3:0]      o_round;
    logic            o_vld;
    logic            o_last;
    logic            o_key_loaded;
    logic            o_err;

    int checks   = 0;
    int failures = 0;

    logic [127:0]  keys [0:NR];
    logic [127:0]  alt  [0:NR];
    logic [0:SW-1] sched_a;
    logic [0:SW-1] sched_b;

    round_key_sequencer #(.nk(4), .nr(NR)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_w(i_w), .i_vld(i_vld),
        .i_start(i_start), .i_dec(i_dec), .i_rdy(i_rdy),
        .o_key(o_key), .o_round(o_round), .o_vld(o_vld), .o_last(o_last),
        .o_key_loaded(o_key_loaded), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        int exp_round;
        int cyc;
        logic rdy_now;
        logic [3:0] rdy_pat;

        keys[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        keys[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        keys[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        keys[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        keys[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        keys[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        keys[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        keys[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        keys[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        keys[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        keys[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        for (int k = 0; k <= NR; k++) begin
            alt[k] = ~keys[k];
            sched_a[128*k +: 128] = keys[k];
            sched_b[128*k +: 128] = alt[k];
        end

        i_rst = 1'b1; i_w = '0; i_vld = 1'b0; i_start = 1'b0; i_dec = 1'b0; i_rdy = 1'b0;
        step(); step();
        i_rst = 1'b0;
        chk("rst_vld",    128'(o_vld), 128'd0);
        chk("rst_key",    128'(o_key), 128'd0);
        chk("rst_round",  128'(o_round), 128'd0);
        chk("rst_loaded", 128'(o_key_loaded), 128'd0);
        chk("rst_err",    128'(o_err), 128'd0);

        // Start with nothing loaded.
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("nokey_err", 128'(o_err), 128'd1);
        chk("nokey_vld", 128'(o_vld), 128'd0);
        step();
        chk("nokey_err_clr", 128'(o_err), 128'd0);
        chk("nokey_vld2",    128'(o_vld), 128'd0);

        // Load schedule.
        i_w = sched_a; i_vld = 1'b1;
        step();
        i_vld = 1'b0; i_w = '0;
        chk("load_loaded", 128'(o_key_loaded), 128'd1);
        chk("load_vld",    128'(o_vld), 128'd0);

        // Encrypt with i_rdy high; i_start stays high to show it is ignored mid-stream.
        i_rdy = 1'b1; i_dec = 1'b0; i_start = 1'b1;
        step();
        for (int r = 0; r <= NR; r++) begin
            chk($sformatf("enc_vld_%0d", r),   128'(o_vld), 128'd1);
            chk($sformatf("enc_round_%0d", r), 128'(o_round), 128'(r));
            chk($sformatf("enc_key_%0d", r),   o_key, keys[r]);
            chk($sformatf("enc_last_%0d", r),  128'(o_last), 128'(r == NR));
            step();
        end
        i_start = 1'b0;
        chk("enc_end_vld",   128'(o_vld), 128'd0);
        chk("enc_end_last",  128'(o_last), 128'd0);
        chk("enc_end_key",   o_key, keys[NR]);
        chk("enc_end_round", 128'(o_round), 128'(NR));
        step();
        chk("enc_gap_vld", 128'(o_vld), 128'd0);

        // Decrypt with i_rdy pattern 1,0,0,1 repeating.
        rdy_pat = 4'b1001;
        i_dec = 1'b1; i_start = 1'b1; i_rdy = 1'b0;
        step();
        i_start = 1'b0;
        exp_round = NR;
        cyc = 0;
        while (cyc < 100) begin
            rdy_now = rdy_pat[3 - (cyc % 4)];
            i_rdy = rdy_now;
            chk($sformatf("dec_vld_c%0d", cyc),   128'(o_vld), 128'd1);
            chk($sformatf("dec_round_c%0d", cyc), 128'(o_round), 128'(exp_round));
            chk($sformatf("dec_key_c%0d", cyc),   o_key, keys[exp_round]);
            chk($sformatf("dec_last_c%0d", cyc),  128'(o_last), 128'(exp_round == 0));
            step();
            cyc++;
            if (rdy_now) begin
                if (exp_round == 0) break;
                exp_round--;
            end
        end
        chk("dec_timeout", 128'(cyc < 100), 128'd1);
        chk("dec_end_vld", 128'(o_vld), 128'd0);
        chk("dec_end_key", o_key, keys[0]);

        // Reload during a stream is ignored, then captured once idle.
        i_rdy = 1'b1; i_dec = 1'b0; i_start = 1'b1;
        step();
        i_start = 1'b0;
        i_w = sched_b; i_vld = 1'b1;
        for (int r = 0; r <= NR; r++) begin
            chk($sformatf("busy_key_%0d", r), o_key, keys[r]);
            step();
        end
        chk("busy_end_vld", 128'(o_vld), 128'd0);
        step();
        i_vld = 1'b0; i_w = '0;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("reload_key0", o_key, alt[0]);
        step();
        chk("reload_key1", o_key, alt[1]);
        step(); step(); step();
        chk("mid_round4", 128'(o_round), 128'd4);
        chk("mid_key4",   o_key, alt[4]);

        // Reset mid-stream.
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        chk("midrst_vld",    128'(o_vld), 128'd0);
        chk("midrst_key",    128'(o_key), 128'd0);
        chk("midrst_loaded", 128'(o_key_loaded), 128'd0);
        chk("midrst_round",  128'(o_round), 128'd0);
        step();
        chk("midrst_vld2", 128'(o_vld), 128'd0);

        // Start together with the schedule strobe uses the new schedule.
        i_w = sched_a; i_vld = 1'b1; i_start = 1'b1; i_dec = 1'b1; i_rdy = 1'b0;
        step();
        i_vld = 1'b0; i_start = 1'b0; i_w = '0;
        chk("same_cyc_vld",    128'(o_vld), 128'd1);
        chk("same_cyc_round",  128'(o_round), 128'(NR));
        chk("same_cyc_key",    o_key, keys[NR]);
        chk("same_cyc_loaded", 128'(o_key_loaded), 128'd1);
        step();
        chk("hold_key",   o_key, keys[NR]);
        chk("hold_round", 128'(o_round), 128'(NR));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
